// File: rtl/return_stack_pkg.sv
// Shared constants and operation decode for the return-address stack.
// RS_ADDR_W   : program address width (PC width)
// RS_DEPTH    : number of stack entries (power of two, >= 2)
// RS_PTR_W    : log2(RS_DEPTH)
// op_e        : what one clock edge does to the stack, decoded from push/pop
package return_stack_pkg;

  localparam int RS_ADDR_W = 8;
  localparam int RS_DEPTH  = 4;
  localparam int RS_PTR_W  = $clog2(RS_DEPTH);

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11   // push and pop together: overwrite the top in place
  } op_e;

  function automatic op_e decode_op(input logic push, input logic pop);
    op_e op;
    case ({pop, push})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_REPLACE;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack with saturating occupancy and sticky
// overflow/underflow flags. Consumes the decoder's JMS/BBL strobes and feeds
// the top entry to the PC input mux.
//
// Ports:
//   clk        core clock, state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   push       push strobe (JMS)
//   pop        pop strobe (BBL)
//   push_addr  return address to store
//   clr_err    synchronous clear of the sticky flags (a same-edge set wins)
//   ret_addr   current top entry, mem[sp-1 mod DEPTH], combinational
//   depth      occupancy 0..DEPTH
//   empty      depth == 0
//   full       depth == DEPTH
//   overflow   sticky: a push happened while full
//   underflow  sticky: a pop happened while empty
//
// Strobe semantics: there is no valid/ready handshake. Every cycle in which
// push or pop is high is one operation, so a strobe held N cycles acts N
// times; the stack is always ready and ret_addr is always valid (stale after
// an underflow).
module return_stack
  import return_stack_pkg::*;
#(
  parameter int ADDR_W = RS_ADDR_W,
  parameter int DEPTH  = RS_DEPTH,
  parameter int PTR_W  = RS_PTR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] ret_addr,
  output logic [PTR_W:0]    depth,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W:0]   DEPTH_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp;        // next free slot; top is sp-1
  logic [PTR_W-1:0]  sp_top;
  logic [PTR_W:0]    depth_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              set_ovf;
  logic              set_unf;
  op_e               op;

  always_comb begin
    op       = decode_op(push, pop);
    sp_top   = sp - PTR_ONE;   // modulo DEPTH by width
    empty    = (depth_q == '0);
    full     = (depth_q == DEPTH_MAX);
    set_ovf  = (op == OP_PUSH) && full;
    set_unf  = (op == OP_POP) && empty;
  end

  // Read of the pre-edge top: during the BBL cycle this is the address being
  // popped, which the PC loads on the same edge.
  assign ret_addr  = mem[sp_top];
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sp          <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (op)
        OP_PUSH: begin
          // When full the write lands on the oldest entry (circular wrap).
          mem[sp] <= push_addr;
          sp      <= sp + PTR_ONE;
          if (!full) depth_q <= depth_q + DEPTH_ONE;
        end
        OP_POP: begin
          // sp wraps even when empty; depth saturates at zero.
          sp <= sp - PTR_ONE;
          if (!empty) depth_q <= depth_q - DEPTH_ONE;
        end
        OP_REPLACE: begin
          mem[sp_top] <= push_addr;
        end
        default: ;
      endcase
      // Set has priority over clear.
      overflow_q  <= set_ovf | (overflow_q  & ~clr_err);
      underflow_q <= set_unf | (underflow_q & ~clr_err);
    end
  end

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack (ADDR_W=8, DEPTH=4).
// The driver applies one operation per cycle shortly after the rising edge,
// pushes the state the stack must show during that cycle into a queue, then
// advances a behavioural model. The monitor pops and compares on every
// falling edge.
module tb_return_stack;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int EXP_W  = ADDR_W + PTR_W + 1 + 4;

  logic              clk;
  logic              rst_n;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic              clr_err;
  logic [ADDR_W-1:0] ret_addr;
  logic [PTR_W:0]    depth;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .clr_err   (clr_err),
    .ret_addr  (ret_addr),
    .depth     (depth),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_mem [DEPTH];
  int          m_sp;
  int          m_depth;
  bit          m_ovf;
  bit          m_unf;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_sp = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
  endfunction

  function automatic void model_step(bit p, bit q, int addr, bit clr);
    bit so, su;
    so = 0; su = 0;
    if (p && q) begin
      m_mem[(m_sp + DEPTH - 1) % DEPTH] = addr;
    end else if (p) begin
      if (m_depth == DEPTH) so = 1; else m_depth++;
      m_mem[m_sp] = addr;
      m_sp = (m_sp + 1) % DEPTH;
    end else if (q) begin
      if (m_depth == 0) su = 1; else m_depth--;
      m_sp = (m_sp + DEPTH - 1) % DEPTH;
    end
    m_ovf = so ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = su ? 1'b1 : (clr ? 1'b0 : m_unf);
  endfunction

  function automatic logic [EXP_W-1:0] model_word();
    logic [ADDR_W-1:0] top;
    logic [PTR_W:0]    d;
    top = ADDR_W'(m_mem[(m_sp + DEPTH - 1) % DEPTH]);
    d   = (PTR_W+1)'(m_depth);
    return {top, d, (m_depth == 0), (m_depth == DEPTH), m_ovf, m_unf};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  string            tag_q[$];
  int               checks;
  int               errors;

  initial begin
    checks = 0;
    errors = 0;
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] g;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = {ret_addr, depth, empty, full, overflow, underflow};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s @%0t: got ret=%h depth=%0d empty=%b full=%b ovf=%b unf=%b, exp ret=%h depth=%0d empty=%b full=%b ovf=%b unf=%b",
                 t, $time, g[EXP_W-1 -: ADDR_W], g[6:4], g[3], g[2], g[1], g[0],
                 e[EXP_W-1 -: ADDR_W], e[6:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit p, input bit q, input int addr, input bit clr, input string tag);
    @(posedge clk);
    #2;
    push      = p;
    pop       = q;
    push_addr = ADDR_W'(addr);
    clr_err   = clr;
    exp_q.push_back(model_word());
    tag_q.push_back(tag);
    model_step(p, q, addr, clr);
  endtask

  task automatic do_push(input int addr, input string tag);
    cycle(1, 0, addr, 0, tag);
  endtask

  task automatic do_pop(input string tag);
    cycle(0, 1, 0, 0, tag);
  endtask

  task automatic idle(input string tag);
    cycle(0, 0, 0, 0, tag);
  endtask

  // Assert reset mid-cycle (asynchronous), hold one cycle, then release.
  task automatic apply_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push = 0; pop = 0; push_addr = '0; clr_err = 0;
    model_reset();
    exp_q.push_back(model_word());
    tag_q.push_back(tag);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.push_back(model_word());
    tag_q.push_back(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    push = 0; pop = 0; push_addr = '0; clr_err = 0;
    model_reset();
    apply_reset("reset_initial");

    // Reset mid-run after two pushes discards them.
    do_push(8'hA1, "pre_reset_push");
    do_push(8'hA2, "pre_reset_push");
    apply_reset("reset_midrun");
    idle("after_reset");

    // Nested calls.
    do_push(8'h10, "nested_push");
    do_push(8'h20, "nested_push");
    do_push(8'h30, "nested_push");
    do_pop("nested_pop");
    do_pop("nested_pop");
    do_pop("nested_pop");
    idle("nested_end");

    // Overflow: five pushes into four entries, oldest lost.
    for (int i = 1; i <= 5; i++) do_push(i, "ovf_push");
    // Set-vs-clear: push while full with clr_err high keeps overflow set.
    cycle(1, 0, 8'h06, 1, "ovf_set_vs_clr");
    idle("ovf_after_set_vs_clr");
    cycle(0, 0, 0, 1, "ovf_clear");
    for (int i = 0; i < 4; i++) do_pop("ovf_pop");
    idle("ovf_drained");

    // Underflow, then clear.
    do_pop("unf_pop");
    cycle(0, 0, 0, 1, "unf_clr");
    idle("unf_cleared");

    // Simultaneous push+pop replaces the top.
    apply_reset("reset_before_replace");
    do_push(8'h10, "replace_setup");
    do_push(8'h20, "replace_setup");
    cycle(1, 1, 8'h55, 0, "replace");
    idle("replace_result");
    apply_reset("reset_before_replace_empty");
    cycle(1, 1, 8'h77, 0, "replace_empty");
    idle("replace_empty_result");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        apply_reset("rand_reset");
      end else begin
        bit p, q, c;
        p = ($urandom_range(0, 99) < 50);
        q = ($urandom_range(0, 99) < 45);
        c = ($urandom_range(0, 99) < 10);
        cycle(p, q, $urandom_range(0, 255), c, "random");
      end
    end
    idle("final");
    idle("final");

    // Let the monitor drain, bounded.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
